// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: RISC-V instruction-fetch stage.
// Keeps the PC and issues sequential word reads to a 1-cycle-latency
// synchronous imem. Returned words are buffered with their PC in a
// DEPTH-entry prefetch FIFO that feeds decode over a valid/ready handshake.
// An execute-stage redirect flushes the FIFO, drops the in-flight response
// and restarts fetch at the target.
// Optional feature macro: FETCH_PERF_CNT_EN adds the flush/stall counters.
module fetch_prefetch_queue #(
  parameter int                XLEN     = 32,
  parameter int                ILEN     = 32,
  parameter int                DEPTH    = 4,
  parameter logic [XLEN-1:0]   RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pc_select_execute,
  input  logic [XLEN-1:0]            pc_target_execute,
  output logic                       imem_req_valid,
  output logic [XLEN-1:0]            imem_addr,
  input  logic [ILEN-1:0]            imem_rsp_data,
  input  logic                       decode_ready,
  output logic                       fetch_valid,
  output logic [ILEN-1:0]            instruction_fetch,
  output logic [XLEN-1:0]            pc_fetch,
  output logic [XLEN-1:0]            next_pc_fetch,
  output logic [$clog2(DEPTH+1)-1:0] fetch_count
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]                perf_flush_cnt,
  output logic [31:0]                perf_stall_cnt
`endif
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [ILEN-1:0] NOP = ILEN'(32'h0000_0013);

  logic [XLEN-1:0] r_pc;
  logic            r_inflight;
  logic [XLEN-1:0] r_inflight_pc;
  logic [ILEN-1:0] r_mem_ins [DEPTH];
  logic [XLEN-1:0] r_mem_pc  [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;

  logic            w_pop;
  logic            w_push;
  logic            w_issue;
  logic [CW:0]     w_occ;
  logic [XLEN-1:0] w_target;

  // Handshake, reservation-based issue and aligned redirect target
  always_comb begin
    w_pop    = fetch_valid && decode_ready;
    // the in-flight response already owns a slot, so count it as occupied
    w_occ    = {1'b0, r_count} + (CW+1)'(r_inflight) - (CW+1)'(w_pop);
    w_issue  = !rst && !pc_select_execute && (w_occ < (CW+1)'(DEPTH));
    // a redirect in the response cycle discards that response
    w_push   = r_inflight && !pc_select_execute;
    w_target = pc_target_execute & ~XLEN'(3);
  end

  // PC and in-flight tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else begin
      if (pc_select_execute)
        r_pc <= w_target;
      else if (w_issue)
        r_pc <= r_pc + XLEN'(4);
      r_inflight <= w_issue;
      if (w_issue)
        r_inflight_pc <= r_pc;
    end
  end

  // FIFO pointers and occupancy; redirect empties the queue
  always_ff @(posedge clk) begin
    if (rst || pc_select_execute) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // FIFO storage: write the returned word with the PC it was fetched from
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem_ins[r_wptr] <= imem_rsp_data;
      r_mem_pc[r_wptr]  <= r_inflight_pc;
    end
  end

  // Head presentation; an empty head shows a NOP at PC 0
  always_comb begin
    fetch_valid       = (r_count != '0);
    instruction_fetch = fetch_valid ? r_mem_ins[r_rptr] : NOP;
    pc_fetch          = fetch_valid ? r_mem_pc[r_rptr]  : '0;
    next_pc_fetch     = pc_fetch + XLEN'(4);
    imem_req_valid    = w_issue;
    imem_addr         = r_pc;
    fetch_count       = r_count;
  end

`ifdef FETCH_PERF_CNT_EN
  // Redirect and decode-backpressure counters, free-running and wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_flush_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (pc_select_execute)
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      if (fetch_valid && !decode_ready)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: directed phases from the test plan plus a
// random phase. A monitor keeps a program-order model of what decode should
// see (sequential PCs from the last reset/redirect target) and of the next
// imem address, and checks every pop and every request against it.
module tb_fetch_prefetch_queue;
  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] XORK = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_select_execute = 1'b0;
  logic [31:0] pc_target_execute = '0;
  logic [31:0] imem_rsp_data = '0;
  logic        decode_ready = 1'b0;
  logic        imem_req_valid;
  logic [31:0] imem_addr;
  logic        fetch_valid;
  logic [31:0] instruction_fetch;
  logic [31:0] pc_fetch;
  logic [31:0] next_pc_fetch;
  logic [2:0]  fetch_count;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_flush_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  fetch_prefetch_queue #(.XLEN(32), .ILEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .pc_select_execute(pc_select_execute), .pc_target_execute(pc_target_execute),
    .imem_req_valid(imem_req_valid), .imem_addr(imem_addr), .imem_rsp_data(imem_rsp_data),
    .decode_ready(decode_ready), .fetch_valid(fetch_valid),
    .instruction_fetch(instruction_fetch), .pc_fetch(pc_fetch),
    .next_pc_fetch(next_pc_fetch), .fetch_count(fetch_count)
`ifdef FETCH_PERF_CNT_EN
    , .perf_flush_cnt(perf_flush_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction memory: data derived from the address, garbage when idle
  always @(posedge clk)
    imem_rsp_data <= imem_req_valid ? (imem_addr ^ XORK) : $urandom;

  // ---------------- scoreboard / reference model ----------------
  typedef struct packed { logic [31:0] pc; logic [31:0] ins; } ent_t;
  ent_t        exp_q[$];
  logic [31:0] stream_tail;
  logic [31:0] exp_addr = RESET_PC;
  int          req_cnt = 0;

  task automatic restart(input logic [31:0] t);
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back({t + 32'(4*i), (t + 32'(4*i)) ^ XORK});
    stream_tail = t + 32'd64;
  endtask

  // Monitor: everything sampled mid-cycle
  always @(negedge clk) begin
    ent_t e;
    logic [31:0] t;
    check("count_le_depth", 64'(fetch_count <= 3'(DEPTH)), 64'(1));
    check("valid_vs_count", 64'(fetch_valid), 64'(fetch_count != 3'd0));
    if (!fetch_valid) begin
      check("empty_instr", 64'(instruction_fetch), 64'(32'h13));
      check("empty_pc", 64'(pc_fetch), 64'(0));
      check("empty_next_pc", 64'(next_pc_fetch), 64'(4));
    end
    if (rst) begin
      check("req_in_reset", 64'(imem_req_valid), 64'(0));
      restart(RESET_PC);
      exp_addr = RESET_PC;
    end else begin
      if (fetch_valid && decode_ready) begin
        e = exp_q.pop_front();
        exp_q.push_back({stream_tail, stream_tail ^ XORK});
        stream_tail = stream_tail + 32'd4;
        check("pop_pc", 64'(pc_fetch), 64'(e.pc));
        check("pop_instr", 64'(instruction_fetch), 64'(e.ins));
        check("pop_next_pc", 64'(next_pc_fetch), 64'(e.pc + 32'd4));
      end
      if (imem_req_valid) begin
        check("req_addr", 64'(imem_addr), 64'(exp_addr));
        check("req_during_redirect", 64'(pc_select_execute), 64'(0));
        exp_addr = exp_addr + 32'd4;
        req_cnt++;
      end
      if (pc_select_execute) begin
        t = pc_target_execute & ~32'd3;
        restart(t);
        exp_addr = t;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns in the first cycle with rst low
  task automatic do_reset(input logic rdy);
    rst = 1'b1; pc_select_execute = 1'b0; decode_ready = rdy;
    step(); step();
    rst = 1'b0;
  endtask

  initial begin
    int base;
    // Reset state
    step();
    @(negedge clk);
    check("rst_valid", 64'(fetch_valid), 64'(0));
    check("rst_req", 64'(imem_req_valid), 64'(0));
    check("rst_count", 64'(fetch_count), 64'(0));

    // Phase 1: reset release, streaming with decode_ready=1
    do_reset(1'b1);
    @(negedge clk);
    check("p1_req0", 64'({imem_req_valid, imem_addr}), 64'({1'b1, 32'h0}));
    check("p1_valid_R", 64'(fetch_valid), 64'(0));
    step(); @(negedge clk);
    check("p1_req1", 64'({imem_req_valid, imem_addr}), 64'({1'b1, 32'h4}));
    check("p1_valid_R1", 64'(fetch_valid), 64'(0));
    step(); @(negedge clk);
    check("p1_head_valid", 64'(fetch_valid), 64'(1));
    check("p1_head_pc", 64'(pc_fetch), 64'(0));
    check("p1_head_instr", 64'(instruction_fetch), 64'(32'hA5A5_0000));
    for (int i = 0; i < 8; i++) begin
      step(); @(negedge clk);
      check("p1_throughput", 64'({fetch_valid, imem_req_valid}), 64'(2'b11));
    end

    // Phase 2: decode stalled, FIFO saturates, then drains in order
    do_reset(1'b0);
    base = req_cnt;
    repeat (8) step();
    @(negedge clk);
    check("p2_full_count", 64'(fetch_count), 64'(DEPTH));
    check("p2_no_req", 64'(imem_req_valid), 64'(0));
    check("p2_req_total", 64'(req_cnt - base), 64'(4));
    step(); decode_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("p2_drain_pc", 64'(pc_fetch), 64'(32'(4*i)));
      step();
    end

    // Phase 3: redirect with 3 entries buffered and a request in flight
    do_reset(1'b0);
    repeat (4) step();
    pc_select_execute = 1'b1; pc_target_execute = 32'h0000_0103;
    @(negedge clk);
    check("p3_pre_count", 64'(fetch_count), 64'(3));
    check("p3_no_req_redirect", 64'(imem_req_valid), 64'(0));
    step(); pc_select_execute = 1'b0; decode_ready = 1'b1;
    @(negedge clk);
    check("p3_flush_count", 64'(fetch_count), 64'(0));
    check("p3_flush_valid", 64'(fetch_valid), 64'(0));
    check("p3_target_req", 64'({imem_req_valid, imem_addr}), 64'({1'b1, 32'h100}));
    step(); @(negedge clk);
    check("p3_valid_n2", 64'(fetch_valid), 64'(0));
    step(); @(negedge clk);
    check("p3_head", 64'({fetch_valid, pc_fetch}), 64'({1'b1, 32'h100}));

    // Phase 4: back-to-back redirects, last target wins
    repeat (4) step();
    pc_select_execute = 1'b1; pc_target_execute = 32'h40;
    @(negedge clk);
    check("p4_no_req_a", 64'(imem_req_valid), 64'(0));
    step(); pc_target_execute = 32'h80;
    @(negedge clk);
    check("p4_no_req_b", 64'(imem_req_valid), 64'(0));
    step(); pc_select_execute = 1'b0;
    @(negedge clk);
    check("p4_req_80", 64'({imem_req_valid, imem_addr}), 64'({1'b1, 32'h80}));
    step(); step(); @(negedge clk);
    check("p4_head_80", 64'({fetch_valid, pc_fetch}), 64'({1'b1, 32'h80}));

    // Phase 5: reset mid-stream with 3 entries
    do_reset(1'b0);
    repeat (3) step();
    step(); rst = 1'b1;
    @(negedge clk);
    check("p5_pre_count", 64'(fetch_count), 64'(3));
    step(); @(negedge clk);
    check("p5_rst_state", 64'({fetch_valid, fetch_count, imem_req_valid}), 64'(0));
    step(); rst = 1'b0; decode_ready = 1'b1;
    @(negedge clk);
    check("p5_restart", 64'({imem_req_valid, imem_addr}), 64'({1'b1, RESET_PC}));

`ifdef FETCH_PERF_CNT_EN
    // Phase 6: 5 stall cycles then 2 redirects
    do_reset(1'b0);
    step(); step();
    @(negedge clk);
    check("p6_valid", 64'(fetch_valid), 64'(1));
    repeat (5) step();
    decode_ready = 1'b1; pc_select_execute = 1'b1; pc_target_execute = 32'h200;
    step(); pc_target_execute = 32'h300;
    step(); pc_select_execute = 1'b0;
    @(negedge clk);
    check("p6_stall_cnt", 64'(perf_stall_cnt), 64'(5));
    check("p6_flush_cnt", 64'(perf_flush_cnt), 64'(2));
`endif

    // Phase 7: random traffic against the model
    for (int i = 0; i < 600; i++) begin
      step();
      decode_ready      = ($urandom % 4) != 0;
      pc_select_execute = ($urandom % 16) == 0;
      pc_target_execute = $urandom;
      rst               = ($urandom % 64) == 0;
    end
    step();
    rst = 1'b0; pc_select_execute = 1'b0; decode_ready = 1'b1;
    repeat (10) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
